// File: rtl/uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver with a valid/ready holding register, framing and overrun flags.
// Define UART_RX_PARITY_EN to receive start + 8 data + even parity + stop frames.
module uart_rx_oversampled #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int unsigned DIV    = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SMP_W  = $clog2(OVERSAMPLE);
    localparam int unsigned SMP_LO = OVERSAMPLE / 2 - 1;
    localparam int unsigned SMP_MD = OVERSAMPLE / 2;
    localparam int unsigned SMP_HI = OVERSAMPLE / 2 + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd5,
`endif
        BREAK  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         sync_q;
    logic               rx_s;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick_c;
    logic [SMP_W-1:0]   smp_cnt, smp_nxt, smp_step_c;
    logic [2:0]         bit_idx, bit_nxt;
    logic [7:0]         shift_q, shift_nxt;
    logic [1:0]         maj_q, maj_nxt;
    logic               maj_c;
    logic               brk_high_q, brk_nxt;
    logic               deliver_c;
    logic [7:0]         rx_data_nxt;
    logic               rx_valid_nxt;
    logic               frame_err_nxt;
    logic               overrun_nxt;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_nxt;
    logic               parity_err_nxt;
`endif

    assign rx_s       = sync_q[1];
    assign tick_c     = (div_cnt == DIV_W'(DIV - 1));
    assign smp_step_c = (smp_cnt == SMP_W'(OVERSAMPLE - 1)) ? '0 : smp_cnt + SMP_W'(1);
    // Third sample is the live line value at the commit tick.
    assign maj_c      = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);

    // Synchronizer and free-running sample tick divider
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            div_cnt <= '0;
        end else begin
            sync_q  <= {sync_q[0], uart_rx};
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            smp_cnt    <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            maj_q      <= 2'b11;
            brk_high_q <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            smp_cnt    <= smp_nxt;
            bit_idx    <= bit_nxt;
            shift_q    <= shift_nxt;
            maj_q      <= maj_nxt;
            brk_high_q <= brk_nxt;
            rx_data    <= rx_data_nxt;
            rx_valid   <= rx_valid_nxt;
            frame_err  <= frame_err_nxt;
            overrun    <= overrun_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_nxt;
            parity_err <= parity_err_nxt;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Frame FSM and holding-register control
    always_comb begin
        state_nxt     = state;
        smp_nxt       = smp_cnt;
        bit_nxt       = bit_idx;
        shift_nxt     = shift_q;
        maj_nxt       = maj_q;
        brk_nxt       = brk_high_q;
        deliver_c     = 1'b0;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = rx_valid;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt    = par_bad_q;
        parity_err_nxt = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (tick_c && !rx_s) begin
                    state_nxt = START;
                    smp_nxt   = '0;
                end
            end
            BREAK: begin
                // Line must read high on two consecutive ticks with no low in between.
                if (!rx_s) begin
                    brk_nxt = 1'b0;
                end else if (tick_c) begin
                    if (brk_high_q) state_nxt = IDLE;
                    else            brk_nxt   = 1'b1;
                end
            end
            default: begin
                if (tick_c) begin
                    smp_nxt = smp_step_c;
                    if (smp_step_c == SMP_W'(SMP_LO)) maj_nxt[0] = rx_s;
                    if (smp_step_c == SMP_W'(SMP_MD)) maj_nxt[1] = rx_s;
                    if (smp_step_c == SMP_W'(SMP_HI)) begin
                        case (state)
                            START: begin
                                if (maj_c) begin
                                    state_nxt = IDLE;
                                end else begin
                                    state_nxt = DATA;
                                    bit_nxt   = '0;
                                end
                            end
                            DATA: begin
                                shift_nxt = {maj_c, shift_q[7:1]};
                                bit_nxt   = bit_idx + 3'd1;
                                if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                    state_nxt = PARITY;
`else
                                    state_nxt = STOP;
`endif
                                end
                            end
`ifdef UART_RX_PARITY_EN
                            PARITY: begin
                                par_bad_nxt = maj_c ^ (^shift_q);
                                state_nxt   = STOP;
                            end
`endif
                            STOP: begin
                                if (maj_c) begin
                                    state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                                    if (par_bad_q) parity_err_nxt = 1'b1;
                                    else           deliver_c      = 1'b1;
`else
                                    deliver_c = 1'b1;
`endif
                                end else begin
                                    frame_err_nxt = 1'b1;
                                    brk_nxt       = 1'b0;
                                    state_nxt     = BREAK;
                                end
                            end
                            default: state_nxt = IDLE;
                        endcase
                    end
                end
            end
        endcase

        // Accept and deliver in the same cycle keeps rx_valid high with the new byte.
        if (deliver_c) begin
            if (!rx_valid || rx_ready) begin
                rx_data_nxt  = shift_q;
                rx_valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled; honours UART_RX_PARITY_EN when defined.
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = ((50_000_000 + 115200 * 8) / (115200 * 16)) * 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    int n_perr = 0;
    logic [7:0] exp_q[$];

    uart_rx_oversampled dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_ok);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_ok ? ^d : ~^d);
`endif
        send_bit(stop_v);
    endtask

    // Monitor: pop and compare whenever a new byte appears in the holding register
    initial begin
        logic prev_valid;
        logic [7:0] e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rx_valid && (!prev_valid || rx_ready)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h with empty queue", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e));
                end
            end
            if (frame_err)  n_ferr++;
            if (overrun)    n_ovr++;
            if (parity_err) n_perr++;
            prev_valid = rx_valid;
        end
    end

    initial begin
        int f0, o0, p0;
        bit found;
        reset    = 1'b1;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #2;
        check("reset_rx_valid",   32'(rx_valid),   32'd0);
        check("reset_rx_data",    32'(rx_data),    32'h00);
        check("reset_frame_err",  32'(frame_err),  32'd0);
        check("reset_overrun",    32'(overrun),    32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        @(negedge clk);
        repeat (BIT_CLKS) @(negedge clk);

        // 1: 0x55 with consumer ready
        f0 = n_ferr; o0 = n_ovr;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t1_valid_dropped", 32'(rx_valid), 32'd0);
        check("t1_no_frame_err",  32'(n_ferr - f0), 32'd0);
        check("t1_no_overrun",    32'(n_ovr - o0), 32'd0);

        // 2: 3-tick low glitch is rejected
        f0 = n_ferr;
        uart_rx = 1'b0;
        repeat (3 * BIT_CLKS / 16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("t2_no_frame_err", 32'(n_ferr - f0), 32'd0);
        check("t2_no_valid",     32'(rx_valid), 32'd0);

        // 3: bad stop followed by a long break, then a clean byte
        f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b1);
        uart_rx = 1'b0;
        repeat (19 * BIT_CLKS) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("t3_one_frame_err", 32'(n_ferr - f0), 32'd1);
        check("t3_no_valid",      32'(rx_valid), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (4) @(negedge clk);

        // 4: overrun with consumer stalled
        o0 = n_ovr;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_overrun_once", 32'(n_ovr - o0), 32'd1);
        check("t4_held_data",    32'(rx_data), 32'h11);
        check("t4_held_valid",   32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(posedge clk); #2;
        check("t4_valid_drop",   32'(rx_valid), 32'd0);
        check("t4_data_kept",    32'(rx_data), 32'h11);
        @(negedge clk);

        // 5: accept coincides with delivery of the next byte
        o0 = n_ovr;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        exp_q.push_back(8'h22);
        found = 1'b0;
        fork
            send_frame(8'h22, 1'b1, 1'b1);
            begin
                for (int i = 0; i < 12 * BIT_CLKS && !found; i++) begin
                    @(negedge clk);
                    if (dut.deliver_c) begin
                        rx_ready = 1'b1;
                        found = 1'b1;
                        @(posedge clk); #2;
                        check("t5_valid_no_bubble", 32'(rx_valid), 32'd1);
                        check("t5_new_data",        32'(rx_data), 32'h22);
                    end
                end
                if (!found) check("t5_delivery_timeout", 32'd0, 32'd1);
            end
        join
        rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_overrun", 32'(n_ovr - o0), 32'd0);

        // 6: reset in the middle of a frame aborts it
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h7E >> i));
        uart_rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("t6_no_valid",     32'(rx_valid), 32'd0);
        check("t6_data_cleared", 32'(rx_data), 32'h00);
        check("t6_no_frame_err", 32'(n_ferr - f0), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (4) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // Parity error drops the byte; correct parity is accepted
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("par_err_pulse", 32'(n_perr - p0), 32'd1);
        check("par_no_valid",  32'(rx_valid), 32'd0);
        check("par_no_ferr",   32'(n_ferr - f0), 32'd0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
`else
        p0 = n_perr;
`endif
        check("no_stray_parity_err", 32'(n_perr - p0), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
